// File: rtl/prog_mod_counter.sv
// prog_mod_counter: programmable-modulo up/down counter with one-shot halt.
//
// Counts over 0..modulo in either direction.  A wrap produces a one-cycle
// terminal pulse.  In one-shot mode the first wrap halts the counter until
// the next preset.
//
// Parameters
//   WIDTH      counter width in bits (2..32)
//   RESET_VAL  count value loaded on reset, clamped to modulo
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   en            count enable
//   up_dn         direction: 1 = up, 0 = down
//   one_shot      1 = halt after the first wrap, 0 = periodic
//   modulo        terminal value; the count range is 0..modulo
//   preset        synchronous load strobe
//   preset_input  load value, clamped to modulo
//   count         current count (registered)
//   tpulse        terminal pulse, one cycle per wrap (registered)
//   done          one-shot halted flag (registered)
module prog_mod_counter #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] modulo,
  input  logic             preset,
  input  logic [WIDTH-1:0] preset_input,
  output logic [WIDTH-1:0] count,
  output logic             tpulse,
  output logic             done
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tpulse_nxt;
  logic             done_nxt;

  logic [WIDTH-1:0] reset_val_c;
  logic [WIDTH-1:0] preset_val_c;
  logic             wrap_c;
  logic             step_c;

  // Load values are clamped into the legal range 0..modulo.
  assign reset_val_c  = (RESET_VAL > modulo) ? modulo : RESET_VAL;
  assign preset_val_c = (preset_input > modulo) ? modulo : preset_input;

  // Out-of-range counts (modulo lowered at runtime) are treated as a wrap.
  assign wrap_c = up_dn ? (count >= modulo)
                        : ((count == '0) || (count > modulo));

  // A counting step happens only when running, enabled and not preloading.
  assign step_c = !preset && (state == RUN) && en;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      count  <= reset_val_c;
      tpulse <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      tpulse <= tpulse_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state logic: preset always returns to RUN; one-shot wrap halts.
  always_comb begin
    state_nxt = state;
    if (preset) begin
      state_nxt = RUN;
    end else if (step_c && wrap_c && one_shot) begin
      state_nxt = HALT;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    count_nxt  = count;
    tpulse_nxt = 1'b0;
    if (preset) begin
      count_nxt = preset_val_c;
    end else if (step_c) begin
      if (wrap_c) begin
        count_nxt  = up_dn ? '0 : modulo;
        tpulse_nxt = 1'b1;
      end else begin
        count_nxt = up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
      end
    end
    done_nxt = (state_nxt == HALT);
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, the value `count` takes on reset (WIDTH bits).
REQ-003 The block SHALL have the following ports:
- clk  input  1  rising-edge clock, the only clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  direction: 1 = up, 0 = down.
- one_shot  input  1  mode: 1 = stop after the first wrap, 0 = periodic.
- modulo  input  WIDTH  terminal value `max_val`; the count range is 0..max_val.
- preset  input  1  synchronous load strobe.
- preset_input  input  WIDTH  load value.
- count  output  WIDTH  current count, registered.
- tpulse  output  1  terminal pulse, registered, one cycle wide.
- done  output  1  one-shot halted flag, registered.

Function
REQ-004 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-005 Per-edge priority SHALL be: reset > preset > halted > en; with en=0 and no preset, count holds and tpulse=0.
REQ-006 The FSM SHALL have two states:
- RUN: counting.
- HALT: stopped; entered only when one_shot=1 at a wrap event.
REQ-007 Up counting (RUN, en=1, up_dn=1), per edge:
- count < max_val: count increments by 1, tpulse=0.
- count == max_val: count goes to 0 (wrap) and tpulse=1 for exactly that following cycle.
REQ-008 Down counting (RUN, en=1, up_dn=0), per edge:
- count > 0: count decrements by 1, tpulse=0.
- count == 0: count goes to max_val (wrap) and tpulse=1.
REQ-009 If count > max_val (modulo lowered at runtime), the next enabled edge SHALL treat it as a wrap: up goes to 0, down goes to max_val, tpulse=1.
REQ-010 With max_val = 0, count SHALL stay 0 and tpulse SHALL be 1 on every enabled edge.
REQ-011 Changing up_dn mid-run SHALL take effect on the next edge with no lost or duplicated step.
REQ-012 One-shot: at a wrap with one_shot=1, the FSM SHALL move to HALT.
- count takes the wrapped value; tpulse=1 for that one cycle.
- done=1 from the same edge onward.
REQ-013 In HALT, count SHALL hold, tpulse SHALL be 0 and en SHALL be ignored.
- Only preset or reset leaves HALT; done clears on the same edge.
REQ-014 Clearing one_shot while in HALT SHALL NOT resume counting (a preset is still required).
REQ-015 Preset (any state) SHALL load count = min(preset_input, max_val), force tpulse=0, enter RUN and clear done, with latency 1 edge.
REQ-016 Preset on the same edge as a wrap SHALL win: no tpulse and no HALT entry.
REQ-017 tpulse SHALL never be high for two consecutive cycles unless max_val = 0 and en stays high.
REQ-018 Arithmetic SHALL be modulo-2^WIDTH internally; max_val = 2^WIDTH-1 gives the full binary range.

Reset
REQ-019 On reset assertion, independent of clk, the block SHALL immediately set:
- count = RESET_VAL clamped to modulo.
- tpulse = 0, done = 0, state = RUN.
REQ-020 While reset is high, all other inputs SHALL be ignored.
REQ-021 On deassertion, counting SHALL begin on the first rising edge after deassertion if en=1.
REQ-022 Reset asserted mid-count or in HALT SHALL abort the operation with no tpulse.

Verification
REQ-023 Up wrap: WIDTH=8, modulo=9, en=1, up_dn=1, from 0 -> count 0..9 then 0; tpulse high for exactly one cycle, every 10th cycle.
REQ-024 Down wrap: modulo=5, up_dn=0, preset_input=2 -> count 2,1,0,5,4; tpulse high in the cycle count=5.
REQ-025 One-shot: modulo=3, one_shot=1, en=1 from 0 -> count 1,2,3,0 then holds 0; done=1, a single tpulse, en toggling has no effect; a preset with preset_input=1 restarts at 1 with done=0.
REQ-026 Clamp/simultaneous: modulo=7, preset_input=200 -> count=7; preset asserted on the wrap edge (count=7, up) -> count=preset value, tpulse=0.
REQ-027 Async reset: assert reset between edges at count=0x5A -> count=RESET_VAL, tpulse=0, done=0 before the next edge; deassert -> increments on the next edge.
REQ-028 Full range and direction change: modulo=255 up from 254 -> 255, 0 with tpulse; flip up_dn at count=100 -> next value 99; max_val=0 -> tpulse high every enabled cycle.
